// File: rtl/seg_pkg.sv
// Shared seven-segment definitions: segment bit order, hex-to-segment table and capture FSM states.
package seg_pkg;

   localparam int unsigned SEG_W  = 7;
   localparam int unsigned HEX_W  = 4;
   localparam int unsigned DIG_N  = 4;
   localparam int unsigned SLOT_W = 2;
   localparam int unsigned VAL_W  = DIG_N * HEX_W;

   // Segment positions in the internal {A..G} bus, A is the MSB
   localparam int unsigned SEG_A = 6;
   localparam int unsigned SEG_B = 5;
   localparam int unsigned SEG_C = 4;
   localparam int unsigned SEG_D = 3;
   localparam int unsigned SEG_E = 2;
   localparam int unsigned SEG_F = 1;
   localparam int unsigned SEG_G = 0;

   localparam logic [SEG_W-1:0] HEX2SEG [16] = '{
      7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
      7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
      7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
      7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
   };

   typedef enum logic {
      COLLECT = 1'b0,
      PUBLISH = 1'b1
   } state_t;

endpackage

// File: rtl/seg2hex.sv
// Reverse lookup of an active-high segment pattern into a hex nibble; hit is low for unknown patterns.
module seg2hex
   import seg_pkg::*;
(
   input  logic [SEG_W-1:0] seg,
   output logic [HEX_W-1:0] hex,
   output logic             hit
);

   always_comb begin
      hex = '0;
      hit = 1'b0;
      for (int i = 0; i < 16; i++) begin
         if (seg == HEX2SEG[i]) begin
            hex = HEX_W'(i);
            hit = 1'b1;
         end
      end
   end

endmodule

// File: rtl/seg_scan_capture.sv
// Captures a scanned 4-digit seven-segment display back into a 16-bit value:
// synchronize, debounce, decode, then assemble one frame of four digits.
module seg_scan_capture
   import seg_pkg::*;
#(
   parameter int unsigned STABLE_CYCLES  = 4,
   parameter int unsigned TIMEOUT_CYCLES = 65536,
   parameter bit          EN_ACTIVE_LOW  = 1'b1,
   parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             DS_EN1,
   input  logic             DS_EN2,
   input  logic             DS_EN3,
   input  logic             DS_EN4,
   input  logic             DS_A,
   input  logic             DS_B,
   input  logic             DS_C,
   input  logic             DS_D,
   input  logic             DS_E,
   input  logic             DS_F,
   input  logic             DS_G,
   output logic [VAL_W-1:0] VALUE,
   output logic             VALID,
   output logic             ERR,
   output logic             LOCKED
);

   localparam int unsigned SMP_W = DIG_N + SEG_W;
   localparam int unsigned CNT_W = 8;
   localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [SEG_W-1:0]  raw_seg;
   logic [SMP_W-1:0]  raw, sync1, sync2, prev;
   logic [DIG_N-1:0]  en_n;
   logic [SEG_W-1:0]  seg_n;
   logic [CNT_W-1:0]  stab_cnt;
   logic              same, accept;
   logic [HEX_W-1:0]  dec_hex;
   logic              dec_hit;
   logic [SLOT_W-1:0] slot;
   logic              one_hot, none;
   logic              cls_good, cls_err;
   logic [SLOT_W-1:0] cls_slot;
   logic [HEX_W-1:0]  cls_hex;
   logic [DIG_N-1:0]  slot_bit;
   logic [TMO_W-1:0]  tmo_cnt;
   logic              tmo_hit;
   state_t            state, state_nxt;
   logic [DIG_N-1:0]  mask, mask_nxt;
   logic [VAL_W-1:0]  shadow, shadow_nxt, value_nxt;
   logic              valid_nxt, err_nxt, locked_nxt;

   always_comb begin
      raw_seg        = '0;
      raw_seg[SEG_A] = DS_A;
      raw_seg[SEG_B] = DS_B;
      raw_seg[SEG_C] = DS_C;
      raw_seg[SEG_D] = DS_D;
      raw_seg[SEG_E] = DS_E;
      raw_seg[SEG_F] = DS_F;
      raw_seg[SEG_G] = DS_G;
   end

   assign raw   = {DS_EN4, DS_EN3, DS_EN2, DS_EN1, raw_seg};
   assign en_n  = sync2[SMP_W-1:SEG_W] ^ {DIG_N{EN_ACTIVE_LOW}};
   assign seg_n = sync2[SEG_W-1:0] ^ {SEG_W{SEG_ACTIVE_LOW}};

   // Accept exactly once, on the STABLE_CYCLES-th identical sample; counter saturates to avoid re-acceptance
   assign same   = (sync2 == prev);
   assign accept = same ? (stab_cnt == CNT_W'(STABLE_CYCLES - 1)) : (STABLE_CYCLES == 1);

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         sync1    <= '0;
         sync2    <= '0;
         prev     <= '0;
         stab_cnt <= '0;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
         prev  <= sync2;
         if (!same)
            stab_cnt <= CNT_W'(1);
         else if (stab_cnt != '1)
            stab_cnt <= stab_cnt + CNT_W'(1);
      end
   end

   seg2hex u_seg2hex (
      .seg (seg_n),
      .hex (dec_hex),
      .hit (dec_hit)
   );

   always_comb begin
      slot = '0;
      for (int i = 0; i < DIG_N; i++)
         if (en_n[i]) slot = SLOT_W'(i);
   end

   assign one_hot = $onehot(en_n);
   assign none    = (en_n == '0);

   // Classification stage; blanking produces neither event
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         cls_good <= 1'b0;
         cls_err  <= 1'b0;
         cls_slot <= '0;
         cls_hex  <= '0;
      end else begin
         cls_good <= accept && one_hot && dec_hit;
         cls_err  <= accept && !none && !(one_hot && dec_hit);
         cls_slot <= slot;
         cls_hex  <= dec_hex;
      end
   end

   assign slot_bit = DIG_N'(1) << cls_slot;
   assign tmo_hit  = (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) && !cls_good;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST)
         tmo_cnt <= '0;
      else if (cls_good || tmo_hit)
         tmo_cnt <= '0;
      else
         tmo_cnt <= tmo_cnt + TMO_W'(1);
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) state <= COLLECT;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = COLLECT;
      if (state == COLLECT && cls_good && !cls_err && ((mask | slot_bit) == '1))
         state_nxt = PUBLISH;
   end

   // An error landing in the PUBLISH cycle (only possible with STABLE_CYCLES=1) drops the
   // partial frame silently so that VALID and ERR never coincide
   always_comb begin
      mask_nxt   = mask;
      shadow_nxt = shadow;
      value_nxt  = VALUE;
      valid_nxt  = 1'b0;
      err_nxt    = 1'b0;
      locked_nxt = LOCKED;
      if (state == PUBLISH) begin
         value_nxt  = shadow;
         valid_nxt  = 1'b1;
         locked_nxt = 1'b1;
         mask_nxt   = '0;
      end
      if (tmo_hit) begin
         mask_nxt   = '0;
         locked_nxt = 1'b0;
      end
      if (cls_err) begin
         mask_nxt = '0;
         err_nxt  = (state == COLLECT);
      end else if (cls_good) begin
         shadow_nxt[cls_slot*HEX_W +: HEX_W] = cls_hex;
         mask_nxt = mask_nxt | slot_bit;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         mask   <= '0;
         shadow <= '0;
         VALUE  <= '0;
         VALID  <= 1'b0;
         ERR    <= 1'b0;
         LOCKED <= 1'b0;
      end else begin
         mask   <= mask_nxt;
         shadow <= shadow_nxt;
         VALUE  <= value_nxt;
         VALID  <= valid_nxt;
         ERR    <= err_nxt;
         LOCKED <= locked_nxt;
      end
   end

endmodule

// File: tb/tb_seg_scan_capture.sv
// Directed bench for seg_scan_capture: drives active-low scan frames and checks frame capture behavior.
module tb_seg_scan_capture;

   logic        CLK = 1'b0;
   logic        RST;
   logic        DS_EN1, DS_EN2, DS_EN3, DS_EN4;
   logic        DS_A, DS_B, DS_C, DS_D, DS_E, DS_F, DS_G;
   logic [15:0] VALUE;
   logic        VALID, ERR, LOCKED;

   int total = 0;
   int bad   = 0;
   int n_valid = 0, n_err = 0, n_both = 0;
   int v0, e0;

   seg_scan_capture #(
      .STABLE_CYCLES  (4),
      .TIMEOUT_CYCLES (64),
      .EN_ACTIVE_LOW  (1'b1),
      .SEG_ACTIVE_LOW (1'b1)
   ) dut (
      .CLK    (CLK),
      .RST    (RST),
      .DS_EN1 (DS_EN1),
      .DS_EN2 (DS_EN2),
      .DS_EN3 (DS_EN3),
      .DS_EN4 (DS_EN4),
      .DS_A   (DS_A),
      .DS_B   (DS_B),
      .DS_C   (DS_C),
      .DS_D   (DS_D),
      .DS_E   (DS_E),
      .DS_F   (DS_F),
      .DS_G   (DS_G),
      .VALUE  (VALUE),
      .VALID  (VALID),
      .ERR    (ERR),
      .LOCKED (LOCKED)
   );

   always #5 CLK = ~CLK;

   always @(negedge CLK) begin
      if (!RST) begin
         if (VALID) n_valid = n_valid + 1;
         if (ERR) n_err = n_err + 1;
         if (VALID && ERR) n_both = n_both + 1;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [6:0] seg_of(input logic [3:0] h);
      case (h)
         4'h0: return 7'b1111110;
         4'h1: return 7'b0110000;
         4'h2: return 7'b1101101;
         4'h3: return 7'b1111001;
         4'h4: return 7'b0110011;
         4'h5: return 7'b1011011;
         4'h6: return 7'b1011111;
         4'h7: return 7'b1110000;
         4'h8: return 7'b1111111;
         4'h9: return 7'b1111011;
         4'hA: return 7'b1110111;
         4'hB: return 7'b0011111;
         4'hC: return 7'b1001110;
         4'hD: return 7'b0111101;
         4'hE: return 7'b1001111;
         default: return 7'b1000111;
      endcase
   endfunction

   // en and pat are active-high; the pins are driven active-low
   task automatic drive(input logic [3:0] en, input logic [6:0] pat, input int cyc);
      @(negedge CLK);
      {DS_EN4, DS_EN3, DS_EN2, DS_EN1} = ~en;
      {DS_A, DS_B, DS_C, DS_D, DS_E, DS_F, DS_G} = ~pat;
      repeat (cyc - 1) @(negedge CLK);
   endtask

   task automatic blank(input int cyc);
      drive(4'b0000, 7'b0000000, cyc);
   endtask

   task automatic frame(input logic [15:0] v);
      drive(4'b0001, seg_of(v[3:0]), 8);
      drive(4'b0010, seg_of(v[7:4]), 8);
      drive(4'b0100, seg_of(v[11:8]), 8);
      drive(4'b1000, seg_of(v[15:12]), 8);
      blank(4);
   endtask

   initial begin
      RST = 1'b1;
      {DS_EN4, DS_EN3, DS_EN2, DS_EN1} = 4'hF;
      {DS_A, DS_B, DS_C, DS_D, DS_E, DS_F, DS_G} = 7'h7F;
      repeat (3) @(negedge CLK);
      check("rst_value", VALUE, 16'h0000);
      check("rst_valid", VALID, 1'b0);
      check("rst_err", ERR, 1'b0);
      check("rst_locked", LOCKED, 1'b0);
      RST = 1'b0;
      blank(4);

      // nominal frame
      v0 = n_valid; e0 = n_err;
      frame(16'h1234);
      check("nom_valid_cnt", n_valid - v0, 1);
      check("nom_value", VALUE, 16'h1234);
      check("nom_locked", LOCKED, 1'b1);
      check("nom_err_cnt", n_err - e0, 0);

      // 2-cycle glitch on EN2 is never accepted
      v0 = n_valid; e0 = n_err;
      drive(4'b0001, seg_of(4'h8), 8);
      drive(4'b0010, seg_of(4'h7), 3);
      drive(4'b0010, 7'b0000001, 2);
      drive(4'b0010, seg_of(4'h7), 8);
      drive(4'b0100, seg_of(4'h6), 8);
      drive(4'b1000, seg_of(4'h5), 8);
      blank(4);
      check("glitch_valid_cnt", n_valid - v0, 1);
      check("glitch_value", VALUE, 16'h5678);
      check("glitch_err_cnt", n_err - e0, 0);

      // unknown pattern on EN2 mid-frame
      v0 = n_valid; e0 = n_err;
      drive(4'b0001, seg_of(4'hF), 8);
      drive(4'b0010, 7'b0000001, 8);
      drive(4'b0100, seg_of(4'hE), 8);
      drive(4'b1000, seg_of(4'hB), 8);
      blank(4);
      check("badpat_err_cnt", n_err - e0, 1);
      check("badpat_valid_cnt", n_valid - v0, 0);
      check("badpat_value_hold", VALUE, 16'h5678);
      v0 = n_valid;
      frame(16'hBEEF);
      check("beef_valid_cnt", n_valid - v0, 1);
      check("beef_value", VALUE, 16'hBEEF);
      check("beef_err_cnt", n_err - e0, 1);

      // two enables at once clears the mask
      v0 = n_valid; e0 = n_err;
      drive(4'b0101, seg_of(4'h1), 8);
      blank(4);
      check("dual_err_cnt", n_err - e0, 1);
      check("dual_value_hold", VALUE, 16'hBEEF);
      drive(4'b0001, seg_of(4'h0), 8);
      drive(4'b0010, seg_of(4'h0), 8);
      blank(4);
      check("dual_mask_cleared", n_valid - v0, 0);
      drive(4'b0100, seg_of(4'h6), 8);
      drive(4'b1000, seg_of(4'h7), 8);
      blank(4);
      check("dual_valid_cnt", n_valid - v0, 1);
      check("dual_value", VALUE, 16'h7600);

      // timeout after a good frame
      e0 = n_err;
      frame(16'h0F0F);
      check("tmo_locked_start", LOCKED, 1'b1);
      blank(40);
      check("tmo_locked_mid", LOCKED, 1'b1);
      blank(30);
      check("tmo_locked_end", LOCKED, 1'b0);
      check("tmo_value_hold", VALUE, 16'h0F0F);
      check("tmo_err_cnt", n_err - e0, 0);

      // reset mid-frame discards collected digits
      drive(4'b0100, seg_of(4'h9), 8);
      drive(4'b1000, seg_of(4'h9), 8);
      @(negedge CLK);
      RST = 1'b1;
      {DS_EN4, DS_EN3, DS_EN2, DS_EN1} = 4'hF;
      {DS_A, DS_B, DS_C, DS_D, DS_E, DS_F, DS_G} = 7'h7F;
      repeat (2) @(negedge CLK);
      check("rst2_value", VALUE, 16'h0000);
      check("rst2_valid", VALID, 1'b0);
      check("rst2_err", ERR, 1'b0);
      check("rst2_locked", LOCKED, 1'b0);
      RST = 1'b0;
      blank(4);
      v0 = n_valid;
      drive(4'b0001, seg_of(4'h3), 8);
      drive(4'b0010, seg_of(4'hC), 8);
      blank(4);
      check("rst2_no_early_valid", n_valid - v0, 0);
      drive(4'b0100, seg_of(4'h5), 8);
      drive(4'b1000, seg_of(4'hA), 8);
      blank(4);
      check("rst2_valid_cnt", n_valid - v0, 1);
      check("rst2_frame_value", VALUE, 16'hA5C3);
      check("rst2_locked_after", LOCKED, 1'b1);

      check("valid_err_overlap", n_both, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
